ascon_input_loader: RTL and testbench

- Upstream feeder for the ASCON encryption FSM.
- Accepts a byte stream over a valid/ready handshake and assembles the key, nonce, associated data and plaintext into wide registers.
- Pulses start_o for one cycle when a complete frame is loaded, then holds all fields stable until the FSM reports done.
- Sits between the host byte link (UART/bus bridge) and the ASCON core.

---
 rtl/ascon_input_loader.sv | 167 ++++++++++++++++
 tb/tb_ascon_input_loader.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ascon_input_loader.sv
// Byte-stream front end for the ASCON core: shifts key, nonce, DA and plaintext into wide registers, pulses start_o, then holds the frame until done.
// Define ASCON_LOADER_TIMEOUT_EN to add the TIMEOUT_CYCLES parameter and the inter-byte gap abort with sticky error_o.
module ascon_input_loader #(
  parameter int unsigned KEY_BYTES   = 16,
  parameter int unsigned NONCE_BYTES = 16,
  parameter int unsigned DA_BYTES    = 8,
  parameter int unsigned PT_BYTES    = 181
`ifdef ASCON_LOADER_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
`endif
) (
  input  logic                    clock_i,
  input  logic                    reset_i,
  input  logic [7:0]              byte_i,
  input  logic                    byte_valid_i,
  output logic                    byte_ready_o,
  input  logic                    done_i,
  output logic                    start_o,
  output logic [8*KEY_BYTES-1:0]  key_o,
  output logic [8*NONCE_BYTES-1:0] nonce_o,
  output logic [8*DA_BYTES-1:0]   da_o,
  output logic [8*PT_BYTES-1:0]   plain_text_o,
  output logic                    busy_o,
  output logic                    error_o
);

  localparam int unsigned N_BYTES = KEY_BYTES + NONCE_BYTES + DA_BYTES + PT_BYTES;
  localparam int unsigned CNT_W   = $clog2(N_BYTES + 1);

  // Cumulative field boundaries, expressed in counter width.
  localparam logic [CNT_W-1:0] C_NONCE = CNT_W'(KEY_BYTES);
  localparam logic [CNT_W-1:0] C_DA    = CNT_W'(KEY_BYTES + NONCE_BYTES);
  localparam logic [CNT_W-1:0] C_PT    = CNT_W'(KEY_BYTES + NONCE_BYTES + DA_BYTES);
  localparam logic [CNT_W-1:0] C_LAST  = CNT_W'(N_BYTES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_BUSY
  } state_t;

  state_t                   r_state;
  logic [CNT_W-1:0]         r_cnt;
  logic [8*KEY_BYTES-1:0]   r_key;
  logic [8*NONCE_BYTES-1:0] r_nonce;
  logic [8*DA_BYTES-1:0]    r_da;
  logic [8*PT_BYTES-1:0]    r_pt;
  logic                     r_ready;
  logic                     r_start;
  logic                     r_busy;
  logic                     r_done_d;

  logic w_accept;
  logic w_done_rise;

`ifdef ASCON_LOADER_TIMEOUT_EN
  localparam int unsigned      GAP_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [GAP_W-1:0] G_LAST = GAP_W'(TIMEOUT_CYCLES - 1);

  logic [GAP_W-1:0] r_gap;
  logic             r_error;
`endif

  assign w_accept    = byte_valid_i & r_ready;
  // done_i may be held as a level; only its rising cycle completes a BUSY phase.
  assign w_done_rise = done_i & ~r_done_d;

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_key    <= '0;
      r_nonce  <= '0;
      r_da     <= '0;
      r_pt     <= '0;
      r_ready  <= 1'b0;
      r_start  <= 1'b0;
      r_busy   <= 1'b0;
      r_done_d <= 1'b0;
`ifdef ASCON_LOADER_TIMEOUT_EN
      r_gap    <= '0;
      r_error  <= 1'b0;
`endif
    end else begin
      r_done_d <= done_i;
      r_start  <= 1'b0;

      // Big-endian assembly: each new byte enters at the LSB, so the first byte ends at the MSB.
      if (w_accept) begin
        if (r_cnt < C_NONCE) begin
          r_key <= (r_key << 8) | {{(8*KEY_BYTES-8){1'b0}}, byte_i};
        end else if (r_cnt < C_DA) begin
          r_nonce <= (r_nonce << 8) | {{(8*NONCE_BYTES-8){1'b0}}, byte_i};
        end else if (r_cnt < C_PT) begin
          r_da <= (r_da << 8) | {{(8*DA_BYTES-8){1'b0}}, byte_i};
        end else begin
          r_pt <= (r_pt << 8) | {{(8*PT_BYTES-8){1'b0}}, byte_i};
        end
`ifdef ASCON_LOADER_TIMEOUT_EN
        r_gap   <= '0;
        r_error <= 1'b0;
`endif
      end

      case (r_state)
        S_IDLE, S_LOAD: begin
          r_ready <= 1'b1;
          if (w_accept) begin
            if (r_cnt == C_LAST) begin
              r_state <= S_START;
              r_ready <= 1'b0;
              r_start <= 1'b1;
              r_busy  <= 1'b1;
            end else begin
              r_state <= S_LOAD;
              r_cnt   <= r_cnt + CNT_W'(1);
            end
          end
`ifdef ASCON_LOADER_TIMEOUT_EN
          else if (r_state == S_LOAD) begin
            // A stalled source abandons the partial frame; the next byte restarts at key byte 0.
            if (r_gap == G_LAST) begin
              r_state <= S_IDLE;
              r_cnt   <= '0;
              r_gap   <= '0;
              r_error <= 1'b1;
            end else begin
              r_gap <= r_gap + GAP_W'(1);
            end
          end
`endif
        end
        S_START: begin
          r_state <= S_BUSY;
        end
        S_BUSY: begin
          if (w_done_rise) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_ready <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign byte_ready_o = r_ready;
  assign start_o      = r_start;
  assign busy_o       = r_busy;
  assign key_o        = r_key;
  assign nonce_o      = r_nonce;
  assign da_o         = r_da;
  assign plain_text_o = r_pt;

`ifdef ASCON_LOADER_TIMEOUT_EN
  assign error_o = r_error;
`else
  assign error_o = 1'b0;
`endif

endmodule

// File: tb/tb_ascon_input_loader.sv
// Self-checking bench for ascon_input_loader: spot-check table, random frames against an array-based field model, and corner sequences.
module tb_ascon_input_loader;

  localparam int KB = 16;
  localparam int NB = 16;
  localparam int DB = 8;
  localparam int PB = 181;
  localparam int N  = KB + NB + DB + PB;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b1;
  logic          vld   = 1'b0;
  logic          done  = 1'b0;
  logic [7:0]    bin   = 8'h00;
  logic          ready, start, busy, err;
  logic [8*KB-1:0] key;
  logic [8*NB-1:0] nonce;
  logic [8*DB-1:0] da;
  logic [8*PB-1:0] pt;

  always #5 clk = ~clk;

  ascon_input_loader #(
    .KEY_BYTES  (KB),
    .NONCE_BYTES(NB),
    .DA_BYTES   (DB),
    .PT_BYTES   (PB)
`ifdef ASCON_LOADER_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES(16)
`endif
  ) dut (
    .clock_i     (clk),
    .reset_i     (rst_n),
    .byte_i      (bin),
    .byte_valid_i(vld),
    .byte_ready_o(ready),
    .done_i      (done),
    .start_o     (start),
    .key_o       (key),
    .nonce_o     (nonce),
    .da_o        (da),
    .plain_text_o(pt),
    .busy_o      (busy),
    .error_o     (err)
  );

  int n_vec   = 0;
  int n_err   = 0;
  int n_start = 0;

  always @(negedge clk) if (start) n_start++;

  // Reference model: the frame as a byte array, fields rebuilt by direct big-endian placement.
  logic [7:0]      fr [N];
  logic [8*KB-1:0] ek;
  logic [8*NB-1:0] en;
  logic [8*DB-1:0] ed;
  logic [8*PB-1:0] ep;

  task automatic build_model();
    for (int i = 0; i < KB; i++) ek[8*(KB-1-i) +: 8] = fr[i];
    for (int i = 0; i < NB; i++) en[8*(NB-1-i) +: 8] = fr[KB+i];
    for (int i = 0; i < DB; i++) ed[8*(DB-1-i) +: 8] = fr[KB+NB+i];
    for (int i = 0; i < PB; i++) ep[8*(PB-1-i) +: 8] = fr[KB+NB+DB+i];
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_bytes(input string nm, input logic [8*PB-1:0] act,
                           input logic [8*PB-1:0] exp, input int nbytes);
    int bad;
    bad = -1;
    n_vec++;
    for (int i = 0; i < nbytes; i++)
      if (bad < 0 && act[8*i +: 8] !== exp[8*i +: 8]) bad = i;
    if (bad >= 0) begin
      n_err++;
      $display("FAIL %s: byte %0d from LSB got %02h, expected %02h",
               nm, bad, act[8*bad +: 8], exp[8*bad +: 8]);
    end
  endtask

  task automatic chk_fields(input string tag);
    chk_bytes({tag, "_key"},   (8*PB)'(key),   (8*PB)'(ek), KB);
    chk_bytes({tag, "_nonce"}, (8*PB)'(nonce), (8*PB)'(en), NB);
    chk_bytes({tag, "_da"},    (8*PB)'(da),    (8*PB)'(ed), DB);
    chk_bytes({tag, "_pt"},    pt,             ep,          PB);
  endtask

  function automatic logic [7:0] get_byte(input int fld, input int idx);
    case (fld)
      0:       return key[8*(KB-1-idx) +: 8];
      1:       return nonce[8*(NB-1-idx) +: 8];
      2:       return da[8*(DB-1-idx) +: 8];
      default: return pt[8*(PB-1-idx) +: 8];
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit got;
    got = 1'b0;
    vld = 1'b1;
    bin = b;
    for (int c = 0; c < 64 && !got; c++) begin
      @(negedge clk);
      got = ready;
      tick();
    end
    vld = 1'b0;
    if (!got) begin
      n_vec++;
      n_err++;
      $display("FAIL accept_timeout: byte %02h not accepted in 64 cycles, required acceptance", b);
    end
  endtask

  task automatic send_range(input int lo, input int hi, input int gap_max, input int done_at);
    for (int i = lo; i <= hi; i++) begin
      send_byte(fr[i]);
      if (i == done_at) begin
        done = 1'b1;
        tick();
        done = 1'b0;
        chk("done_in_load_ignored", {30'd0, busy, ready}, 32'd1);
      end
      if (gap_max > 0 && i != hi) repeat ($urandom_range(gap_max, 0)) tick();
    end
  endtask

  task automatic finish_frame(input string tag, input int s0);
    chk({tag, "_start_latency"}, 32'(start), 32'd1);
    chk({tag, "_busy_in_start"}, {30'd0, busy, ready}, 32'd2);
    tick();
    chk({tag, "_start_one_cycle"}, 32'(start), 32'd0);
    chk_fields(tag);
    chk({tag, "_start_count"}, 32'(n_start - s0), 32'd1);
  endtask

  task automatic done_pulse(input string tag);
    done = 1'b1;
    tick();
    done = 1'b0;
    chk({tag, "_idle_after_done"}, {30'd0, busy, ready}, 32'd1);
  endtask

  typedef struct {
    string      nm;
    int         fld;
    int         idx;
    logic [7:0] exp;
  } spot_t;

  initial begin
    spot_t spots [8];
    int    s0;
    int    rdy_hi;

    spots[0] = '{"key_msb",   0, 0,   8'h00};
    spots[1] = '{"key_lsb",   0, 15,  8'h0F};
    spots[2] = '{"nonce_msb", 1, 0,   8'h10};
    spots[3] = '{"nonce_lsb", 1, 15,  8'h1F};
    spots[4] = '{"da_msb",    2, 0,   8'h20};
    spots[5] = '{"da_lsb",    2, 7,   8'h27};
    spots[6] = '{"pt_msb",    3, 0,   8'h28};
    spots[7] = '{"pt_lsb",    3, 180, 8'hDC};

    // Reset state
    #2 rst_n = 1'b0;
    repeat (3) tick();
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_ctrl", {29'd0, start, busy, err}, 32'd0);
    chk_bytes("rst_key", (8*PB)'(key), '0, KB);
    chk_bytes("rst_pt", pt, '0, PB);
    @(negedge clk) rst_n = 1'b1;
    tick();
    chk("ready_after_reset", 32'(ready), 32'd1);

    // Back-to-back ramp frame
    for (int i = 0; i < N; i++) fr[i] = 8'(i);
    build_model();
    s0 = n_start;
    send_range(0, N-1, 0, -1);
    finish_frame("ramp", s0);
    for (int k = 0; k < 8; k++)
      chk(spots[k].nm, 32'(get_byte(spots[k].fld, spots[k].idx)), 32'(spots[k].exp));

    // Source pushes while BUSY
    rdy_hi = 0;
    vld = 1'b1;
    bin = 8'hAA;
    repeat (20) begin
      @(negedge clk);
      if (ready) rdy_hi++;
      tick();
    end
    vld = 1'b0;
    chk("busy_ready_low_cycles", 32'(rdy_hi), 32'd0);
    chk("busy_held", 32'(busy), 32'd1);
    chk_fields("busy_hold");
    done_pulse("ramp");

    // Random bytes, random gaps, done pulse at byte 50, done during START
    for (int i = 0; i < N; i++) fr[i] = 8'($urandom);
    build_model();
    s0 = n_start;
    send_range(0, N-1, 2, 50);
    done = 1'b1;
    finish_frame("rand_gap", s0);
    done = 1'b0;
    tick();
    tick();
    chk("done_in_start_ignored", {30'd0, busy, ready}, 32'd2);
    done_pulse("rand_gap");

    // Asynchronous reset after byte 100
    for (int i = 0; i < N; i++) fr[i] = 8'($urandom);
    s0 = n_start;
    send_range(0, 99, 0, -1);
    #2 rst_n = 1'b0;
    #1;
    chk("midframe_rst_ctrl", {29'd0, ready, busy, start}, 32'd0);
    chk_bytes("midframe_rst_key", (8*PB)'(key), '0, KB);
    chk_bytes("midframe_rst_pt", pt, '0, PB);
    repeat (2) tick();
    @(negedge clk) rst_n = 1'b1;
    tick();
    chk("midframe_no_start", 32'(n_start - s0), 32'd0);
    for (int i = 0; i < N; i++) fr[i] = 8'(i * 7 + 3);
    build_model();
    s0 = n_start;
    send_range(0, N-1, 0, -1);
    finish_frame("after_rst", s0);

    // Asynchronous reset while BUSY
    #2 rst_n = 1'b0;
    #1;
    chk("busy_rst_ctrl", {29'd0, ready, busy, start}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    chk("busy_rst_ready", 32'(ready), 32'd1);

`ifdef ASCON_LOADER_TIMEOUT_EN
    // Inter-byte gap abort
    s0 = n_start;
    for (int i = 0; i < 10; i++) send_byte(8'(8'h50 + i));
    repeat (15) tick();
    chk("no_early_timeout", 32'(err), 32'd0);
    tick();
    chk("timeout_error", 32'(err), 32'd1);
    chk("timeout_idle", {30'd0, busy, ready}, 32'd1);
    chk("timeout_no_start", 32'(n_start - s0), 32'd0);
    for (int i = 0; i < N; i++) fr[i] = 8'(255 - i);
    build_model();
    send_range(0, 0, 0, -1);
    chk("error_cleared_by_byte", 32'(err), 32'd0);
    send_range(1, N-1, 0, -1);
    finish_frame("after_timeout", s0);
    done_pulse("after_timeout");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at 2 ms, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
